// File: rtl/instr_dispatch_fsm_if.sv
// Bus bundle for the instruction dispatch sequencer.
// Groups the start/length controls, the DDR refill handshake, the
// instruction-memory read port, the per-unit dispatch handshake and the
// status outputs.
//   master : the sequencer (drives req/addr/rd_en/instr_*/status)
//   slave  : the surrounding system (memory, loader, execution units)
interface instr_dispatch_fsm_if #(
  parameter int INSTR_W   = 64,
  parameter int ADDR_W    = 10,
  parameter int NUM_UNITS = 4
);
  logic                 acc_enable;
  logic [ADDR_W-1:0]    prog_len;
  logic                 i_mem_empty;
  logic                 ddr_fetch_req;
  logic                 ddr_fetch_ack;
  logic [ADDR_W-1:0]    i_mem_addr;
  logic                 i_mem_rd_en;
  logic [INSTR_W-1:0]   i_mem_din;
  logic [INSTR_W-1:0]   instr_data;
  logic [NUM_UNITS-1:0] instr_valid;
  logic [NUM_UNITS-1:0] instr_ready;
  logic [NUM_UNITS-1:0] unit_done;
  logic                 busy;
  logic                 prog_done;
  logic                 err_bad_unit;
  logic [ADDR_W:0]      instr_count;

  modport master (
    input  acc_enable, prog_len, i_mem_empty, ddr_fetch_ack, i_mem_din,
           instr_ready, unit_done,
    output ddr_fetch_req, i_mem_addr, i_mem_rd_en, instr_data, instr_valid,
           busy, prog_done, err_bad_unit, instr_count
  );

  modport slave (
    output acc_enable, prog_len, i_mem_empty, ddr_fetch_ack, i_mem_din,
           instr_ready, unit_done,
    input  ddr_fetch_req, i_mem_addr, i_mem_rd_en, instr_data, instr_valid,
           busy, prog_done, err_bad_unit, instr_count
  );
endinterface

// File: rtl/instr_dispatch_fsm.sv
// Top-level instruction sequencer.
// Fetches instructions from the instruction memory (refilling it from DDR
// when empty), decodes the 4-bit unit field in the top bits, dispatches each
// instruction to one execution unit over valid/ready, waits for that unit's
// done pulse and moves on until prog_len instructions or a HALT (unit 4'hF).
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : instr_dispatch_fsm_if.master (memory, DDR refill, dispatch, status)
module instr_dispatch_fsm #(
  parameter int INSTR_W   = 64,
  parameter int ADDR_W    = 10,
  parameter int NUM_UNITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_dispatch_fsm_if.master  bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_CHK, S_LOAD, S_RD, S_CAP, S_DEC, S_DSP, S_EXE, S_ADV, S_FIN
  } state_t;

  localparam logic [ADDR_W:0]   COUNT_ONE = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
  // prog_len == 0 stands for a full memory of 2**ADDR_W instructions
  localparam logic [ADDR_W:0]   COUNT_FULL = {1'b1, {ADDR_W{1'b0}}};

  state_t               state, state_next;
  logic [3:0]           unit;
  logic [NUM_UNITS-1:0] unit_sel;
  logic                 unit_halt;
  logic                 unit_ok;
  logic [ADDR_W:0]      count_inc;
  logic [ADDR_W:0]      count_target;
  logic                 last_instr;

  // The unit field is taken from the captured instruction, which stays
  // stable from DEC through EXE, so the selection needs no extra register.
  assign unit      = bus.instr_data[INSTR_W-1 -: 4];
  assign unit_halt = (unit == 4'hF);
  assign unit_ok   = (unit < 4'(NUM_UNITS));

  always_comb begin
    unit_sel = '0;
    for (int i = 0; i < NUM_UNITS; i++) unit_sel[i] = (unit == 4'(i));
  end

  assign count_inc    = bus.instr_count + COUNT_ONE;
  assign count_target = (bus.prog_len == '0) ? COUNT_FULL : {1'b0, bus.prog_len};
  assign last_instr   = (count_inc == count_target);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next state and the state-decoded outputs. Decoding req/valid from the
  // state means a reset drops them as soon as the state returns to IDLE.
  always_comb begin
    state_next        = state;
    bus.ddr_fetch_req = 1'b0;
    bus.i_mem_rd_en   = 1'b0;
    bus.instr_valid   = '0;
    bus.busy          = (state != S_IDLE);
    bus.prog_done     = 1'b0;
    case (state)
      S_IDLE: if (bus.acc_enable) state_next = S_CHK;
      S_CHK:  state_next = bus.i_mem_empty ? S_LOAD : S_RD;
      S_LOAD: begin
        bus.ddr_fetch_req = 1'b1;
        if (bus.ddr_fetch_ack) state_next = S_CHK;
      end
      S_RD: begin
        bus.i_mem_rd_en = 1'b1;
        state_next      = S_CAP;
      end
      S_CAP: state_next = S_DEC;
      S_DEC: begin
        if (unit_halt)    state_next = S_FIN;
        else if (unit_ok) state_next = S_DSP;
        else              state_next = S_ADV;
      end
      S_DSP: begin
        bus.instr_valid = unit_sel;
        if (|(bus.instr_ready & unit_sel)) state_next = S_EXE;
      end
      // done is only looked at here, so a done coincident with the
      // transfer cycle in DSP is never taken as completion
      S_EXE: if (|(bus.unit_done & unit_sel)) state_next = S_ADV;
      S_ADV: state_next = last_instr ? S_FIN : S_CHK;
      S_FIN: begin
        bus.prog_done = 1'b1;
        state_next    = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.i_mem_addr   <= '0;
      bus.instr_data   <= '0;
      bus.instr_count  <= '0;
      bus.err_bad_unit <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.acc_enable) begin
            bus.i_mem_addr   <= '0;
            bus.instr_count  <= '0;
            bus.err_bad_unit <= 1'b0;
          end
        end
        S_CAP: bus.instr_data <= bus.i_mem_din;
        S_DEC: begin
          // HALT counts as a completed instruction; a bad unit code is
          // counted later in ADV like any completed instruction
          if (unit_halt)     bus.instr_count  <= count_inc;
          else if (!unit_ok) bus.err_bad_unit <= 1'b1;
        end
        S_ADV: begin
          bus.instr_count <= count_inc;
          // address wraps naturally at 2**ADDR_W
          if (!last_instr) bus.i_mem_addr <= bus.i_mem_addr + ADDR_ONE;
        end
        S_FIN: bus.i_mem_addr <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_dispatch_fsm.sv
// Directed bench for instr_dispatch_fsm: a table of whole-program vectors
// run through a generic unit responder, plus hand-written sequences for the
// DDR refill, stalled dispatch with foreign ready/done, and mid-run reset.
module tb_instr_dispatch_fsm;

  localparam int INSTR_W   = 64;
  localparam int ADDR_W    = 10;
  localparam int NUM_UNITS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_dispatch_fsm_if #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .NUM_UNITS(NUM_UNITS)) bus ();

  instr_dispatch_fsm #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .NUM_UNITS(NUM_UNITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Instruction memory model: data one cycle after the read strobe.
  logic [63:0] mem [16];
  always @(posedge clk) begin
    if (bus.i_mem_rd_en) bus.i_mem_din <= mem[bus.i_mem_addr[3:0]];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Program vector: unit code for address i is codes[4*i +: 4]; the k-th
  // dispatch is expected on unit exp_units[4*k +: 4] at address exp_addrs[4*k +: 4].
  typedef struct {
    logic [9:0]  plen;
    logic [15:0] codes;
    logic [15:0] exp_units;
    logic [15:0] exp_addrs;
    int          exp_ndsp;
    int          exp_count;
    int          exp_lat;
    logic        exp_err;
  } vec_t;

  vec_t vecs[5];

  // Wait (bounded) for: 0 = any instr_valid, 1 = prog_done, 2 = ddr_fetch_req.
  task automatic wait_for(input int which, input int maxc, output logic found);
    found = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if ((which == 0 && bus.instr_valid != '0) ||
          (which == 1 && bus.prog_done) ||
          (which == 2 && bus.ddr_fetch_req)) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Generic unit responder: ready rdy_dly cycles into valid, done two cycles
  // after the transfer; runs until three cycles past prog_done.
  task automatic serve(input int rdy_dly, output logic [15:0] units, output logic [15:0] addrs,
                       output int ndsp, output int first_cyc, output int pd);
    int vcyc, dcnt, tail;
    logic [3:0] last;
    logic fin;
    units = '0; addrs = '0; ndsp = 0; first_cyc = -1; pd = 0;
    vcyc = 0; dcnt = -1; tail = 0; fin = 1'b0; last = '0;
    for (int cyc = 1; cyc <= 400 && tail < 3; cyc++) begin
      bus.instr_ready = '0;
      bus.unit_done   = '0;
      if (fin) tail++;
      if (bus.prog_done) begin
        pd++;
        fin = 1'b1;
      end
      if (bus.instr_valid != '0) begin
        if (first_cyc < 0) first_cyc = cyc;
        vcyc++;
        if (vcyc >= rdy_dly) begin
          check("valid_onehot", 64'($onehot(bus.instr_valid)), 64'd1);
          for (int b = 0; b < NUM_UNITS; b++) if (bus.instr_valid[b]) last = 4'(b);
          if (ndsp < 4) begin
            units[4*ndsp +: 4] = last;
            addrs[4*ndsp +: 4] = bus.i_mem_addr[3:0];
          end
          ndsp++;
          bus.instr_ready = bus.instr_valid;
          vcyc = 0;
          dcnt = 2;
        end
      end else if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) bus.unit_done = 4'(1) << last;
      end
      @(negedge clk);
    end
    if (!fin) check("serve_timeout", 64'd0, 64'd1);
  endtask

  task automatic start_run(input logic [9:0] plen, input logic empty);
    bus.prog_len    = plen;
    bus.i_mem_empty = empty;
    bus.acc_enable  = 1'b1;
    @(negedge clk);
    bus.acc_enable  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [15:0] units, addrs;
    int ndsp, first_cyc, pd;
    for (int i = 0; i < 16; i++)
      mem[i] = {(i < 4) ? v.codes[4*i +: 4] : 4'h0, 60'(i)};
    start_run(v.plen, 1'b0);
    check($sformatf("v%0d_busy_start", idx), 64'(bus.busy), 64'd1);
    check($sformatf("v%0d_err_start", idx), 64'(bus.err_bad_unit), 64'd0);
    check($sformatf("v%0d_count_start", idx), 64'(bus.instr_count), 64'd0);
    check($sformatf("v%0d_addr_start", idx), 64'(bus.i_mem_addr), 64'd0);
    serve(2, units, addrs, ndsp, first_cyc, pd);
    check($sformatf("v%0d_ndsp", idx), 64'(ndsp), 64'(v.exp_ndsp));
    check($sformatf("v%0d_units", idx), 64'(units), 64'(v.exp_units));
    check($sformatf("v%0d_addrs", idx), 64'(addrs), 64'(v.exp_addrs));
    check($sformatf("v%0d_latency", idx), 64'(first_cyc), 64'(v.exp_lat));
    check($sformatf("v%0d_prog_done", idx), 64'(pd), 64'd1);
    check($sformatf("v%0d_count", idx), 64'(bus.instr_count), 64'(v.exp_count));
    check($sformatf("v%0d_err", idx), 64'(bus.err_bad_unit), 64'(v.exp_err));
    check($sformatf("v%0d_busy_end", idx), 64'(bus.busy), 64'd0);
  endtask

  initial begin
    logic found;
    logic [15:0] units, addrs;
    int ndsp, first_cyc, pd, nreq, rd_early, stable;
    logic pd_seen;

    vecs[0] = '{plen: 10'd3, codes: 16'h0210, exp_units: 16'h0210, exp_addrs: 16'h0210,
                exp_ndsp: 3, exp_count: 3, exp_lat: 5, exp_err: 1'b0};
    vecs[1] = '{plen: 10'd5, codes: 16'h11F0, exp_units: 16'h0000, exp_addrs: 16'h0000,
                exp_ndsp: 1, exp_count: 2, exp_lat: 5, exp_err: 1'b0};
    vecs[2] = '{plen: 10'd3, codes: 16'h0137, exp_units: 16'h0013, exp_addrs: 16'h0021,
                exp_ndsp: 2, exp_count: 3, exp_lat: 10, exp_err: 1'b1};
    vecs[3] = '{plen: 10'd1, codes: 16'h0002, exp_units: 16'h0002, exp_addrs: 16'h0000,
                exp_ndsp: 1, exp_count: 1, exp_lat: 5, exp_err: 1'b0};
    vecs[4] = '{plen: 10'd4, codes: 16'h0123, exp_units: 16'h0123, exp_addrs: 16'h3210,
                exp_ndsp: 4, exp_count: 4, exp_lat: 5, exp_err: 1'b0};

    bus.acc_enable    = 1'b0;
    bus.prog_len      = '0;
    bus.i_mem_empty   = 1'b0;
    bus.ddr_fetch_ack = 1'b0;
    bus.instr_ready   = '0;
    bus.unit_done     = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_valid", 64'(bus.instr_valid), 64'd0);
    check("rst_req", 64'(bus.ddr_fetch_req), 64'd0);
    check("rst_rd_en", 64'(bus.i_mem_rd_en), 64'd0);
    check("rst_addr", 64'(bus.i_mem_addr), 64'd0);
    check("rst_data", bus.instr_data, 64'd0);
    check("rst_count", 64'(bus.instr_count), 64'd0);
    check("rst_err", 64'(bus.err_bad_unit), 64'd0);
    check("rst_prog_done", 64'(bus.prog_done), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 5; v++) run_vec(vecs[v], v);

    // DDR refill: ack on the 10th cycle of req, no reads before it.
    mem[0] = {4'h1, 60'h0};
    start_run(10'd1, 1'b1);
    check("ld_req_in_chk", 64'(bus.ddr_fetch_req), 64'd0);
    nreq = 0;
    rd_early = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.i_mem_rd_en) rd_early++;
      if (bus.ddr_fetch_req) nreq++;
      if (nreq == 10) begin
        bus.ddr_fetch_ack = 1'b1;
        bus.i_mem_empty   = 1'b0;
        break;
      end
    end
    @(negedge clk);
    bus.ddr_fetch_ack = 1'b0;
    check("ld_req_cycles", 64'(nreq), 64'd10);
    check("ld_req_dropped", 64'(bus.ddr_fetch_req), 64'd0);
    check("ld_rd_before_ack", 64'(rd_early), 64'd0);
    serve(2, units, addrs, ndsp, first_cyc, pd);
    check("ld_ndsp", 64'(ndsp), 64'd1);
    check("ld_unit", 64'(units[3:0]), 64'd1);
    check("ld_prog_done", 64'(pd), 64'd1);
    check("ld_count", 64'(bus.instr_count), 64'd1);

    // Stalled dispatch on unit 1 with foreign ready/done asserted.
    mem[0] = {4'h1, 60'h5};
    start_run(10'd1, 1'b0);
    wait_for(0, 10, found);
    check("st_valid_seen", 64'(found), 64'd1);
    stable = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.instr_valid == 4'b0010) stable++;
      bus.instr_ready = 4'b1101;
      bus.unit_done   = 4'b0100;
      @(negedge clk);
    end
    check("st_valid_stable", 64'(stable), 64'd20);
    check("st_valid_held", 64'(bus.instr_valid), 64'b0010);
    bus.instr_ready = 4'b0010;
    bus.unit_done   = 4'b0110;
    @(negedge clk);
    bus.instr_ready = '0;
    bus.unit_done   = 4'b0100;
    check("st_valid_after_xfer", 64'(bus.instr_valid), 64'd0);
    check("st_busy_exe", 64'(bus.busy), 64'd1);
    pd_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      pd_seen |= bus.prog_done;
    end
    check("st_no_early_done", 64'(pd_seen), 64'd0);
    check("st_count_exe", 64'(bus.instr_count), 64'd0);
    bus.unit_done = 4'b0010;
    @(negedge clk);
    bus.unit_done = '0;
    wait_for(1, 5, found);
    check("st_prog_done", 64'(found), 64'd1);
    check("st_count", 64'(bus.instr_count), 64'd1);
    repeat (2) @(negedge clk);

    // Reset while dispatching the second instruction.
    mem[0] = {4'h0, 60'h0};
    mem[1] = {4'h1, 60'h1};
    start_run(10'd2, 1'b0);
    wait_for(0, 10, found);
    bus.instr_ready = bus.instr_valid;
    @(negedge clk);
    bus.instr_ready = '0;
    @(negedge clk);
    bus.unit_done = 4'b0001;
    @(negedge clk);
    bus.unit_done = '0;
    wait_for(0, 10, found);
    check("rd_second_valid", 64'(bus.instr_valid), 64'b0010);
    check("rd_second_addr", 64'(bus.i_mem_addr), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rd_valid", 64'(bus.instr_valid), 64'd0);
    check("rd_busy", 64'(bus.busy), 64'd0);
    check("rd_addr", 64'(bus.i_mem_addr), 64'd0);
    check("rd_count", 64'(bus.instr_count), 64'd0);
    check("rd_data", bus.instr_data, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Reset while waiting for a DDR refill.
    start_run(10'd1, 1'b1);
    wait_for(2, 10, found);
    check("rl_req_seen", 64'(found), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rl_req", 64'(bus.ddr_fetch_req), 64'd0);
    check("rl_busy", 64'(bus.busy), 64'd0);
    rst = 1'b0;
    bus.i_mem_empty = 1'b0;
    @(negedge clk);

    run_vec(vecs[0], 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
